// File: rtl/dram_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the DRAM controller.
// slave  : the arbiter's view (requests and controller responses in, grants and commands out).
// master : the requester/controller side that drives requests and controller responses.
interface dram_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_rw;
    logic [23*NUM_REQ-1:0] req_addr;
    logic [32*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [31:0]           rsp_data;
    logic [22:0]           mem_addr;
    logic                  mem_rw;
    logic [31:0]           mem_wdata;
    logic                  mem_in_valid;
    logic                  mem_busy;
    logic [31:0]           mem_rdata;
    logic                  mem_out_valid;
    logic                  err_orphan;

    modport slave (
        input  req_valid, req_rw, req_addr, req_data,
        input  mem_busy, mem_rdata, mem_out_valid,
        output req_ready, rsp_valid, rsp_data,
        output mem_addr, mem_rw, mem_wdata, mem_in_valid, err_orphan
    );

    modport master (
        output req_valid, req_rw, req_addr, req_data,
        output mem_busy, mem_rdata, mem_out_valid,
        input  req_ready, rsp_valid, rsp_data,
        input  mem_addr, mem_rw, mem_wdata, mem_in_valid, err_orphan
    );
endinterface

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one DRAM controller between NUM_REQ requesters.
// Reads are tagged with the requester index in an in-order FIFO so returning
// controller data can be routed back to the requester that asked for it.
// Ports: clk, rst (synchronous, active-high), bus (dram_arbiter_if.slave) carrying
// requester handshake, controller command/response and the sticky err_orphan flag.
//
// state  | meaning
// IDLE   | may grant one eligible requester when the controller is not busy
// ISSUE  | command registered onto the controller, mem_in_valid high
// SETTLE | waits out the controller's one-cycle busy latency
module dram_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int TAG_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    dram_arbiter_if.slave  bus
);
    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW   = $clog2(TAG_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;

    state_t              state_q;
    logic [IDXW-1:0]     last_q;
    logic [IDXW-1:0]     tag_q [TAG_DEPTH];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [PW:0]         count_q, count_d;
    logic [22:0]         mem_addr_q;
    logic                mem_rw_q;
    logic [31:0]         mem_wdata_q;
    logic                mem_in_valid_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    logic [31:0]         rsp_data_q;
    logic                err_orphan_q;

    logic [NUM_REQ-1:0]  eligible, grant_oh, pop_oh;
    logic [IDXW-1:0]     winner, cand;
    logic                found, grant, push, pop;

    // Reads need a free tag slot; a pop in the same cycle does not free one early.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = bus.req_valid[i] &
                          (bus.req_rw[i] | (count_q < (PW+1)'(TAG_DEPTH)));
        end
    end

    // Round-robin search starting one past the previous winner.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = last_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (cand == IDXW'(NUM_REQ-1)) ? '0 : cand + 1'b1;
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign grant = (state_q == IDLE) & ~bus.mem_busy & found & ~rst;
    assign push  = grant & ~bus.req_rw[winner];
    assign pop   = bus.mem_out_valid & (count_q != '0);

    always_comb begin
        grant_oh = '0;
        pop_oh   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_oh[i] = grant & (winner == IDXW'(i));
            pop_oh[i]   = (tag_q[rd_ptr_q] == IDXW'(i));
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            last_q         <= IDXW'(NUM_REQ-1);
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            mem_addr_q     <= '0;
            mem_rw_q       <= 1'b0;
            mem_wdata_q    <= '0;
            mem_in_valid_q <= 1'b0;
            rsp_valid_q    <= '0;
            rsp_data_q     <= '0;
            err_orphan_q   <= 1'b0;
        end else begin
            mem_in_valid_q <= grant;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_q     <= ISSUE;
                        last_q      <= winner;
                        mem_addr_q  <= bus.req_addr[int'(winner)*23 +: 23];
                        mem_rw_q    <= bus.req_rw[winner];
                        mem_wdata_q <= bus.req_data[int'(winner)*32 +: 32];
                    end
                end
                ISSUE:   state_q <= SETTLE;
                SETTLE:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            if (push) begin
                tag_q[wr_ptr_q] <= winner;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + 1'b1;
                rsp_valid_q <= pop_oh;
                rsp_data_q  <= bus.mem_rdata;
            end else begin
                rsp_valid_q <= '0;
            end
            if (bus.mem_out_valid && count_q == '0)
                err_orphan_q <= 1'b1;
            count_q <= count_d;
        end
    end

    assign bus.req_ready    = grant_oh;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_rw       = mem_rw_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.mem_in_valid = mem_in_valid_q;
    assign bus.err_orphan   = err_orphan_q;
endmodule

// File: tb/tb_dram_arbiter.sv
module tb_dram_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dram_arbiter_if #(.NUM_REQ(4)) bus ();
    dram_arbiter #(.NUM_REQ(4), .TAG_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit armed = 0;

    // Behavioural model: priority pointer, blocked-cycle counter, tag queue.
    int          m_last;
    int          m_cool;
    int          m_q[$];
    logic        m_err;
    logic [22:0] m_addr;
    logic        m_rw;
    logic [31:0] m_wdata;
    logic        m_inv;
    logic [3:0]  m_rspv;
    logic [31:0] m_rspd;

    int g_idx[$];
    int g_cyc[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_last = 3; m_cool = 0; m_q.delete(); m_err = 0;
        m_addr = '0; m_rw = 0; m_wdata = '0; m_inv = 0; m_rspv = '0; m_rspd = '0;
    endtask

    task automatic step();
        logic [3:0] exp_ready;
        int w;
        int c;
        @(negedge clk);
        exp_ready = '0;
        w = -1;
        if (!rst && m_cool == 0 && !bus.mem_busy) begin
            for (int k = 1; k <= 4; k++) begin
                c = (m_last + k) % 4;
                if (w < 0 && bus.req_valid[c] && (bus.req_rw[c] || m_q.size() < 4)) w = c;
            end
        end
        if (w >= 0) exp_ready[w] = 1'b1;
        if (armed) begin
            chk("req_ready",    bus.req_ready,    exp_ready);
            chk("mem_in_valid", bus.mem_in_valid, m_inv);
            chk("mem_addr",     bus.mem_addr,     m_addr);
            chk("mem_rw",       bus.mem_rw,       m_rw);
            chk("mem_wdata",    bus.mem_wdata,    m_wdata);
            chk("rsp_valid",    bus.rsp_valid,    m_rspv);
            chk("rsp_data",     bus.rsp_data,     m_rspd);
            chk("err_orphan",   bus.err_orphan,   m_err);
        end
        for (int i = 0; i < 4; i++)
            if (bus.req_ready[i] === 1'b1) begin g_idx.push_back(i); g_cyc.push_back(cyc); end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_inv = (w >= 0);
            if (w >= 0) begin
                m_addr  = bus.req_addr[23*w +: 23];
                m_rw    = bus.req_rw[w];
                m_wdata = bus.req_data[32*w +: 32];
                m_last  = w;
                m_cool  = 2;
            end else if (m_cool > 0) begin
                m_cool--;
            end
            m_rspv = '0;
            if (bus.mem_out_valid) begin
                if (m_q.size() > 0) begin
                    m_rspv = 4'b0001 << m_q.pop_front();
                    m_rspd = bus.mem_rdata;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (w >= 0 && !bus.req_rw[w]) m_q.push_back(w);
        end
        cyc++;
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int exp_seq[5];

    initial begin
        rst = 1'b1;
        bus.req_valid = '0; bus.req_rw = '0;
        bus.mem_busy = 1'b0; bus.mem_rdata = '0; bus.mem_out_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.req_addr[23*i +: 23] = 23'h100 + 23'(i);
            bus.req_data[32*i +: 32] = 32'hD0 + 32'(i);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_reset();
        armed = 1;
        step();
        chk("reset_err", bus.err_orphan, 1'b0);
        chk("reset_addr", bus.mem_addr, 23'h0);
        rst = 1'b0;

        // Fairness: all four writing, controller idle.
        g_idx.delete(); g_cyc.delete();
        bus.req_valid = 4'b1111; bus.req_rw = 4'b1111;
        steps(13);
        exp_seq = '{0, 1, 2, 3, 0};
        chk("fair_count", g_idx.size(), 5);
        for (int k = 0; k < 5; k++) begin
            chk("fair_order", (k < g_idx.size()) ? g_idx[k] : 99, exp_seq[k]);
            chk("fair_spacing", (k < g_cyc.size()) ? g_cyc[k] - g_cyc[0] : 99, 3*k);
        end
        chk("fair_addr", bus.mem_addr, 23'h100);
        chk("fair_wdata", bus.mem_wdata, 32'hD0);
        chk("fair_inv", bus.mem_in_valid, 1'b1);
        bus.req_valid = '0;
        steps(2);

        // Busy gating.
        g_idx.delete();
        bus.mem_busy = 1'b1; bus.req_valid = 4'b0100; bus.req_rw = 4'b0100;
        steps(10);
        chk("busy_nogrant", g_idx.size(), 0);
        bus.mem_busy = 1'b0;
        step();
        chk("busy_grant", (g_idx.size() > 0) ? g_idx[g_idx.size()-1] : 99, 2);
        bus.req_valid = '0;
        steps(2);

        // Read routing.
        bus.req_rw = 4'b0000;
        bus.req_valid = 4'b0010; step(); bus.req_valid = '0; steps(2);
        bus.req_valid = 4'b1000; step(); bus.req_valid = '0; steps(2);
        bus.mem_out_valid = 1'b1; bus.mem_rdata = 32'hAABBCCDD; step();
        chk("route1_valid", bus.rsp_valid, 4'b0010);
        chk("route1_data", bus.rsp_data, 32'hAABBCCDD);
        bus.mem_rdata = 32'h11223344; step();
        chk("route2_valid", bus.rsp_valid, 4'b1000);
        chk("route2_data", bus.rsp_data, 32'h11223344);
        bus.mem_out_valid = 1'b0; bus.mem_rdata = 32'h0; step();
        chk("route_hold", bus.rsp_data, 32'h11223344);

        // Full tag FIFO.
        bus.req_valid = 4'b1111; bus.req_rw = 4'b0000;
        steps(10);
        bus.req_valid = '0;
        steps(2);
        g_idx.delete();
        bus.req_valid = 4'b0011; bus.req_rw = 4'b0010;
        step();
        chk("full_write_wins", (g_idx.size() > 0) ? g_idx[0] : 99, 1);
        bus.req_valid = 4'b0001;
        steps(3);
        bus.mem_out_valid = 1'b1; bus.mem_rdata = 32'h5A5A0000;
        step();
        chk("full_stall", g_idx.size(), 1);
        chk("full_pop_route", bus.rsp_valid, 4'b0001);
        bus.mem_out_valid = 1'b0;
        step();
        chk("full_read_wins", (g_idx.size() > 1) ? g_idx[1] : 99, 0);
        bus.req_valid = '0;
        steps(2);
        for (int i = 0; i < 4; i++) begin
            bus.mem_out_valid = 1'b1; bus.mem_rdata = 32'hC0DE0000 + 32'(i); step();
            bus.mem_out_valid = 1'b0; step();
        end

        // Orphan data.
        bus.mem_out_valid = 1'b1; bus.mem_rdata = 32'hDEADBEEF; step();
        chk("orphan_err", bus.err_orphan, 1'b1);
        chk("orphan_rsp", bus.rsp_valid, 4'b0000);
        bus.mem_out_valid = 1'b0;
        rst = 1'b1; step(); rst = 1'b0; step();
        chk("orphan_clear", bus.err_orphan, 1'b0);

        // Reset with reads outstanding.
        bus.req_valid = 4'b0011; bus.req_rw = 4'b0000;
        steps(4);
        bus.req_valid = '0;
        rst = 1'b1; step(); rst = 1'b0;
        bus.mem_out_valid = 1'b1; bus.mem_rdata = 32'h12345678; step();
        chk("midrst_rsp", bus.rsp_valid, 4'b0000);
        chk("midrst_err", bus.err_orphan, 1'b1);
        bus.mem_out_valid = 1'b0; step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the DRAM controller; legal values 2..8.
REQ-002 Parameter TAG_DEPTH, default 4: number of outstanding reads tracked; legal values are powers of two from 2 to 16.
REQ-003 Clock and reset: clk, rising edge; rst, synchronous, active-high.
REQ-004 Signal list (name  direction  width  meaning):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request pending.
- req_rw  in  NUM_REQ  per-requester 1=write, 0=read.
- req_addr  in  23*NUM_REQ  per-requester word address, slice i = [23i+22:23i].
- req_data  in  32*NUM_REQ  per-requester write data.
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse; read data for requester i is valid.
- rsp_data  out  32  read data, shared by all requesters.
- mem_addr  out  23  controller addr.
- mem_rw  out  1  controller rw.
- mem_wdata  out  32  controller write data.
- mem_in_valid  out  1  controller request pulse.
- mem_busy  in  1  controller busy.
- mem_rdata  in  32  controller read data.
- mem_out_valid  in  1  controller read-data-valid pulse.
- err_orphan  out  1  sticky flag: read data arrived with no outstanding tag.

Function
REQ-005 FSM states are IDLE, ISSUE and SETTLE; transitions: IDLE->ISSUE on a grant, ISSUE->SETTLE unconditionally, SETTLE->IDLE unconditionally.
REQ-006 Eligibility: requester i is eligible when req_valid[i]=1 and either req_rw[i]=1 or the tag FIFO count < TAG_DEPTH.
REQ-007 Grant condition: in IDLE with mem_busy=0, the arbiter grants exactly one eligible requester; req_ready is combinational and asserted only in that cycle.
REQ-008 Round-robin order: the search starts at last_grant+1 mod NUM_REQ and takes the first eligible index; last_grant updates to the winner on every grant.
REQ-009 Idle outputs: req_ready is all-zero in ISSUE, in SETTLE, in IDLE when mem_busy=1, and in IDLE when no requester is eligible.
REQ-010 Issue timing: on a grant, the winner's addr/rw/data are registered onto mem_addr/mem_rw/mem_wdata, and mem_in_valid=1 for exactly the ISSUE cycle.
REQ-011 Hold-off: SETTLE covers the controller's one-cycle busy latency, so there is no new grant until mem_busy can reflect the issued request.
REQ-012 mem_addr, mem_rw and mem_wdata hold their values until the next grant.
REQ-013 Issue rate: the minimum grant-to-grant spacing is 3 cycles; with mem_busy held 0, grants occur every 3 cycles.
REQ-014 Tag push: on a read grant, the winner index is pushed into the tag FIFO (depth TAG_DEPTH, in-order); a write grant pushes nothing.
REQ-015 Tag pop: on mem_out_valid=1 with the FIFO non-empty, the head index t is popped; the next cycle has rsp_valid = one-hot(t) for one cycle and rsp_data = mem_rdata.
REQ-016 Read latency: 1 cycle from mem_out_valid to rsp_valid.
REQ-017 Simultaneous push and pop: both operations complete in the same cycle and the count is unchanged.
REQ-018 Full FIFO: a read is ineligible when the count equals TAG_DEPTH, even if a pop occurs in the same cycle; writes remain eligible.
REQ-019 Orphan data: mem_out_valid with an empty FIFO produces no rsp_valid and sets err_orphan=1 until reset.
REQ-020 Data hold: rsp_data holds its last value when rsp_valid=0.
REQ-021 FIFO pointers wrap modulo TAG_DEPTH; the count is log2(TAG_DEPTH)+1 bits wide.

Reset
REQ-022 On rst=1, the arbiter enters IDLE, sets last_grant=NUM_REQ-1 (requester 0 has first priority), empties the tag FIFO, and drives req_ready=0, rsp_valid=0, mem_in_valid=0, err_orphan=0, mem_addr=0, mem_rw=0, mem_wdata=0 and rsp_data=0.
REQ-023 Reset mid-operation: reset discards all outstanding tags, and any later mem_out_valid raises err_orphan rather than producing rsp_valid.

Verification
REQ-024 Fairness: req_valid=4'b1111, all writes, mem_busy=0 -> grants to 0,1,2,3,0 at cycles 0,3,6,9,12, each followed one cycle later by a single mem_in_valid pulse carrying that requester's addr and data.
REQ-025 Busy gating: mem_busy=1 for 10 cycles with req_valid[2]=1 -> req_ready=0 throughout; grant to 2 occurs in the first cycle with mem_busy=0.
REQ-026 Read routing: reads granted from requesters 1 then 3, then mem_out_valid pulsed with 0xAABBCCDD and then 0x11223344 -> rsp_valid=4'b0010 with 0xAABBCCDD, then 4'b1000 with 0x11223344, each one cycle after its mem_out_valid.
REQ-027 Full FIFO: 4 reads outstanding, requester 0 read and requester 1 write pending -> requester 1 is granted and requester 0 stalls; after one mem_out_valid, requester 0 is granted.
REQ-028 Orphan: mem_out_valid=1 with the FIFO empty -> no rsp_valid and err_orphan=1; rst then clears err_orphan to 0.
REQ-029 Mid-operation reset: rst asserted with 2 reads outstanding, then a mem_out_valid pulse -> rsp_valid stays 0 and err_orphan=1.
